// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and index/word types
package regfile_pkg;
  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 16;
  localparam int REG_COUNT  = 64;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [REG_DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// rtl/regfile_writeback_queue_if.sv - enqueue handshake and register-file write ports
interface regfile_writeback_queue_if import regfile_pkg::*; #(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) ();
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] wr1;
  logic [ADDR_W-1:0] wr2;
  logic [DATA_W-1:0] wr1_data;
  logic [DATA_W-1:0] wr2_data;
  logic              wr1_enable;
  logic              wr2_enable;

  modport master (
    output in_valid, in_reg, in_data,
    input  in_ready, wr1, wr2, wr1_data, wr2_data, wr1_enable, wr2_enable
  );

  modport slave (
    input  in_valid, in_reg, in_data,
    output in_ready, wr1, wr2, wr1_data, wr2_data, wr1_enable, wr2_enable
  );
endinterface

// File: rtl/regfile_writeback_queue_forward.sv
// rtl/regfile_writeback_queue_forward.sv - youngest-match search of pending entries for one read index
module wbq_forward import regfile_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_reg,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [PTR_W-1:0]             head,
  input  logic [CNT_W-1:0]             occ,
  input  logic [ADDR_W-1:0]            rd,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (CNT_W'(k) < occ && ent_reg[idx] == rd) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback queue draining up to two results per cycle
module regfile_writeback_queue import regfile_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                         clock,
  input  logic                         reset,
  regfile_writeback_queue_if.slave     wb,
  input  logic                         drain_en,
  input  logic [ADDR_W-1:0]            rd1,
  input  logic [ADDR_W-1:0]            rd2,
  input  logic [ADDR_W-1:0]            rd3,
  output logic                         fwd1_hit,
  output logic                         fwd2_hit,
  output logic                         fwd3_hit,
  output logic [DATA_W-1:0]            fwd1_data,
  output logic [DATA_W-1:0]            fwd2_data,
  output logic [DATA_W-1:0]            fwd3_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][ADDR_W-1:0] q_reg;
  logic [DEPTH-1:0][DATA_W-1:0] q_data;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [PTR_W-1:0]             head_p1;
  logic [CNT_W-1:0]             occ;
  logic [1:0]                   n;
  logic                         enq;

  // Masking occupancy during reset keeps strobes and hits quiet in the reset cycle.
  assign occ         = reset ? '0 : count;
  assign head_p1     = head + PTR_W'(1);
  assign wb.in_ready = (count < CNT_W'(DEPTH));
  assign enq         = wb.in_valid && wb.in_ready;
  assign empty       = (count == '0);

  always_comb begin
    n = 2'd0;
    if (drain_en && occ != '0)
      n = (occ == CNT_W'(1)) ? 2'd1 : 2'd2;
  end

  assign wb.wr1_enable = (n >= 2'd1);
  assign wb.wr2_enable = (n == 2'd2);
  assign wb.wr1        = wb.wr1_enable ? q_reg[head]     : '0;
  assign wb.wr1_data   = wb.wr1_enable ? q_data[head]    : '0;
  assign wb.wr2        = wb.wr2_enable ? q_reg[head_p1]  : '0;
  assign wb.wr2_data   = wb.wr2_enable ? q_data[head_p1] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        q_reg[tail]  <= wb.in_reg;
        q_data[tail] <= wb.in_data;
        tail         <= tail + PTR_W'(1);
      end
      head  <= head + PTR_W'(n);
      count <= count + CNT_W'(enq) - CNT_W'(n);
    end
  end

  wbq_forward #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
    .ent_reg(q_reg), .ent_data(q_data), .head(head), .occ(occ),
    .rd(rd1), .hit(fwd1_hit), .data(fwd1_data)
  );

  wbq_forward #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
    .ent_reg(q_reg), .ent_data(q_data), .head(head), .occ(occ),
    .rd(rd2), .hit(fwd2_hit), .data(fwd2_data)
  );

  wbq_forward #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd3 (
    .ent_reg(q_reg), .ent_data(q_data), .head(head), .occ(occ),
    .rd(rd3), .hit(fwd3_hit), .data(fwd3_data)
  );
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed bench for regfile_writeback_queue
module tb_regfile_writeback_queue;
  import regfile_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        drain_en;
  logic [5:0]  rd1, rd2, rd3;
  logic        fwd1_hit, fwd2_hit, fwd3_hit;
  logic [15:0] fwd1_data, fwd2_data, fwd3_data;
  logic [2:0]  count;
  logic        empty;
  logic [15:0] rf [REG_COUNT];
  int          total = 0;
  int          bad = 0;

  regfile_writeback_queue_if wb ();

  regfile_writeback_queue dut (
    .clock(clock), .reset(reset), .wb(wb), .drain_en(drain_en),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd3_hit(fwd3_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .fwd3_data(fwd3_data),
    .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  // Register file: wr2 applied after wr1.
  always @(posedge clock) begin
    if (wb.wr1_enable) rf[wb.wr1] <= wb.wr1_data;
    if (wb.wr2_enable) rf[wb.wr2] <= wb.wr2_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [5:0] r, input logic [15:0] d);
    wb.in_valid = 1'b1;
    wb.in_reg   = r;
    wb.in_data  = d;
  endtask

  initial begin
    for (int i = 0; i < REG_COUNT; i++) rf[i] = '0;
    reset = 1'b1; drain_en = 1'b1; rd1 = '0; rd2 = '0; rd3 = '0;
    offer(6'd3, 16'h0055);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; wb.in_valid = 1'b0; #1;
    check("rst_count", count, 0);
    check("rst_ready", wb.in_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_wr1en", wb.wr1_enable, 0);
    check("rst_wr2en", wb.wr2_enable, 0);
    check("rst_hit", {fwd1_hit, fwd2_hit, fwd3_hit}, 0);

    // single write and forward
    drain_en = 1'b0; offer(6'd5, 16'h1234);
    @(negedge clock);
    wb.in_valid = 1'b0; rd1 = 6'd5; #1;
    check("s_hit", fwd1_hit, 1);
    check("s_fdata", fwd1_data, 16'h1234);
    check("s_nodrain", wb.wr1_enable, 0);
    drain_en = 1'b1; #1;
    check("s_wr1", wb.wr1, 5);
    check("s_wr1d", wb.wr1_data, 16'h1234);
    check("s_wr1en", wb.wr1_enable, 1);
    check("s_wr2en", wb.wr2_enable, 0);
    check("s_hitdrain", fwd1_hit, 1);
    @(negedge clock); #1;
    check("s_empty", empty, 1);
    check("s_gone", fwd1_hit, 0);
    check("s_rf5", rf[5], 16'h1234);

    // same-register dual drain
    drain_en = 1'b0; offer(6'd7, 16'hAAAA);
    @(negedge clock);
    offer(6'd7, 16'hBBBB);
    @(negedge clock);
    wb.in_valid = 1'b0; rd2 = 6'd7; #1;
    check("d_fdata", fwd2_data, 16'hBBBB);
    check("d_count", count, 2);
    drain_en = 1'b1; #1;
    check("d_wr1", {wb.wr1, wb.wr1_data}, {6'd7, 16'hAAAA});
    check("d_wr2", {wb.wr2, wb.wr2_data}, {6'd7, 16'hBBBB});
    check("d_en", {wb.wr1_enable, wb.wr2_enable}, 2'b11);
    @(negedge clock); #1;
    check("d_rf7", rf[7], 16'hBBBB);
    check("d_empty", empty, 1);

    // full and wrap
    drain_en = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      offer(6'(r), 16'h0100 + 16'(r));
      @(negedge clock);
    end
    offer(6'd6, 16'h0666); #1;
    check("f_count", count, 4);
    check("f_ready", wb.in_ready, 0);
    @(negedge clock); #1;
    check("f_drop", count, 4);
    rd1 = 6'd6; #1;
    check("f_nohit6", fwd1_hit, 0);
    drain_en = 1'b1; #1;
    check("f_readydrain", wb.in_ready, 0);
    check("f_pair1", {wb.wr1, wb.wr2}, {6'd1, 6'd2});
    @(negedge clock); #1;
    check("f_ready_rise", wb.in_ready, 1);
    check("f_count2", count, 2);
    check("f_nohit6b", fwd1_hit, 0);
    drain_en = 1'b0; offer(6'd8, 16'h0808);
    @(negedge clock);
    offer(6'd9, 16'h0909);
    @(negedge clock);
    wb.in_valid = 1'b0; drain_en = 1'b1; #1;
    check("f_count4", count, 4);
    check("f_pair2", {wb.wr1, wb.wr2}, {6'd3, 6'd4});
    @(negedge clock); #1;
    check("f_pair3", {wb.wr1, wb.wr2}, {6'd8, 6'd9});
    check("f_pair3d", {wb.wr1_data, wb.wr2_data}, {16'h0808, 16'h0909});
    @(negedge clock); #1;
    check("f_empty", empty, 1);

    // enqueue and drain at count 1
    drain_en = 1'b0; offer(6'd10, 16'h00A0);
    @(negedge clock);
    drain_en = 1'b1; offer(6'd11, 16'h00B0); #1;
    check("c_wr1", wb.wr1, 10);
    check("c_wr2en", wb.wr2_enable, 0);
    @(negedge clock);
    wb.in_valid = 1'b0; #1;
    check("c_count", count, 1);
    check("c_next", {wb.wr1, wb.wr1_data}, {6'd11, 16'h00B0});
    @(negedge clock); #1;
    check("c_empty", empty, 1);

    // reset mid-operation
    drain_en = 1'b0;
    for (int r = 20; r <= 22; r++) begin
      offer(6'(r), 16'h2000 + 16'(r));
      @(negedge clock);
    end
    wb.in_valid = 1'b0; rd3 = 6'd21; #1;
    check("m_hit", fwd3_hit, 1);
    check("m_count", count, 3);
    reset = 1'b1; drain_en = 1'b1; #1;
    check("m_rst_strobe", {wb.wr1_enable, wb.wr2_enable}, 0);
    check("m_rst_hit", fwd3_hit, 0);
    @(negedge clock);
    reset = 1'b0; #1;
    check("m_count0", count, 0);
    check("m_strobe", {wb.wr1_enable, wb.wr2_enable}, 0);
    check("m_nohit", fwd3_hit, 0);
    @(negedge clock); #1;
    check("m_rf20", rf[20], 0);
    check("m_rf21", rf[21], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side companion to the 64×16 three-read/two-write register file. It buffers execute-stage results in a small in-order queue and drains up to two per cycle into the file's `wr1`/`wr2` ports. While results are queued, it forwards the youngest pending value to the three read indices so that readers never see stale data.

## Interface

Parameters:
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `ADDR_W`, default 6: register index width (64 registers).
- `DATA_W`, default 16: register data width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `in_valid` in 1: execute result offered.
- `in_ready` out 1: queue can accept; high when `count < DEPTH`.
- `in_reg` in ADDR_W: destination register index.
- `in_data` in DATA_W: result value.
- `drain_en` in 1: permit writes to the register file this cycle.
- `wr1`, `wr2` out ADDR_W: register-file write indices.
- `wr1_data`, `wr2_data` out DATA_W: register-file write data.
- `wr1_enable`, `wr2_enable` out 1: register-file write strobes.
- `rd1`, `rd2`, `rd3` in ADDR_W: read indices, mirrored from the register-file read ports.
- `fwd1_hit`, `fwd2_hit`, `fwd3_hit` out 1: a pending entry targets the matching `rdN`.
- `fwd1_data`, `fwd2_data`, `fwd3_data` out DATA_W: youngest pending value for `rdN`; 0 when there is no hit.
- `count` out clog2(DEPTH+1): occupied entries.
- `empty` out 1: `count == 0`.

## Operation

- The queue is a circular buffer with `head`, `tail` and `count`.
  - Enqueue fires when `in_valid && in_ready`.
  - Pointers wrap modulo DEPTH.
- Drain is combinational from the head of the queue. The drain amount `n` is:
  - 0 if `!drain_en` or `count == 0`;
  - 1 if `count == 1`;
  - 2 otherwise.
- Port mapping:
  - `wr1` takes the head entry.
  - `wr2` takes the entry at head+1.
  - `wrN_enable` = (`n` ≥ N).
  - Index and data outputs are 0 when the corresponding enable is low.
- Same-register pair: if both drained entries target the same register, both writes are still issued. The register file applies `wr2` after `wr1`, so the younger value wins and program order is preserved.
- Pointer and count updates at the clock edge:
  - `head += n`
  - `tail += enq`
  - `count += enq − n`
- Forwarding is per read port:
  - Search all occupied entries, including those being drained this cycle, for index == `rdN`.
  - Select the youngest (closest to tail).
  - `in_data` offered in the same cycle is never forwarded.
- `in_ready` depends only on the registered `count`. There is no same-cycle pass-through, even when a drain frees a slot.
- Register 0 receives no special treatment; it is written and forwarded like any other index.

## Timing

- Reset values: `head = tail = count = 0`, `empty = 1`, `in_ready = 1`, all `wrN_enable = 0`, all `fwdN_hit = 0`, all data outputs 0.
- An enqueued entry is visible to forwarding and drain on the next cycle (latency 1).
- In the cycle an entry is written to the register file, that entry still forwards. From the next cycle it is gone, and the register file holds the value.
- Full queue (`count == DEPTH`): `in_ready = 0`, and any `in_valid` is ignored.
- Full queue with drain: `in_ready` stays 0 that cycle and rises the next cycle.
- Simultaneous enqueue and drain at `count == 1`: the drain takes the old entry only, and `count` stays 1.
- `drain_en` low freezes the head. The strobes are low while enqueue continues.
- `reset` asserted mid-operation: all pending entries are discarded without being written. No strobe is asserted in the reset cycle.

## Structure

- Shared package `regfile_pkg` holds:
  - `REG_ADDR_W = 6`, `REG_DATA_W = 16`, `REG_COUNT = 64`;
  - typedefs `reg_idx_t` and `reg_word_t`.
  - The register file and this block both import it.
- One sub-module, `wbq_forward`: the youngest-match priority search over DEPTH entries for one read index. It is instantiated three times.
- Queue storage, pointers and drain logic stay in the top module.

## Test plan

- **Reset:** assert `reset` for 2 cycles with `in_valid = 1` → `count = 0`, `in_ready = 1`, no strobes, no hits.
- **Single write and forward:** enqueue (reg 5, 0x1234) with `drain_en = 0`.
  - Next cycle, `rd1 = 5` → `fwd1_hit = 1`, `fwd1_data = 0x1234`.
  - Raise `drain_en` → `wr1 = 5`, `wr1_data = 0x1234`, `wr1_enable = 1`, `wr2_enable = 0`.
  - The cycle after → `empty = 1`.
- **Dual drain with same register:** queue (7, 0xAAAA) then (7, 0xBBBB).
  - With `rd2 = 7` → `fwd2_data = 0xBBBB`.
  - Drain → `wr1 = 7`/0xAAAA and `wr2 = 7`/0xBBBB in one cycle; the register file then reads 0xBBBB.
- **Full and wrap:** fill 4 entries (regs 1..4) with `drain_en = 0`.
  - → `in_ready = 0`; a fifth offer is dropped.
  - Drain 2, enqueue regs 8 and 9 → pointers wrap; the drain order is 3, 4, 8, 9.
- **Simultaneous enqueue and drain at `count = 1`:** → `count` stays 1; the new entry is drained next cycle via `wr1`.
- **Reset mid-operation:** 3 entries pending, reset pulse → no strobes that cycle or later; `count = 0`; `rd3` matching an old index → `fwd3_hit = 0`.
